fm7_psg_audio_out: RTL and testbench
====================================

// Module: fm7_psg_audio_out
// PURPOSE
//  Output stage downstream of the PSG sound block. Takes its unsigned 14-bit mix at CLKSYS rate, box-averages
//  it over 2**DIV_LOG2 cycles and recentres it to signed. Removes DC with a 1-pole high-pass, saturates to
//  signed 16-bit PCM and hands it to the audio sink (serializer/mixer) over a valid/ready register.
// PARAMETERS
//  DIV_LOG2  10  log2 of CLKSYS cycles per output sample (window length); legal 4..16
//  DC_SHIFT  10  high-pass pole: y -= y>>>DC_SHIFT each sample; legal 4..15
// PORTS
//  CLKSYS       in   1   system clock, single clock domain
//  RESETBn      in   1   asynchronous, active-low reset
//  mix_audio_i  in   14  unsigned PSG mix, sampled every CLKSYS cycle
//  mute_i       in   1   force PCM payload to 0 (filter keeps running)
//  pcm_o        out  16  signed PCM sample
//  pcm_valid_o  out  1   pcm_o holds an untaken sample
//  pcm_ready_i  in   1   sink accepts pcm_o when pcm_valid_o & pcm_ready_i
//  overrun_o    out  1   sticky: a sample was overwritten before being taken
//  dsm_o        out  1   1-bit sigma-delta DAC output (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0; window counter, accumulator, x_prev, y_state, DSM accumulator 0. Reset mid-window
//   discards the partial window. First window starts on the first cycle after RESETBn rises.
//  Stage A (window): cnt (DIV_LOG2 bits) increments every cycle and wraps.
//   acc (14+DIV_LOG2 bits) += mix_audio_i.
//   On the cycle cnt==all-ones: avg <= (acc+mix_audio_i)>>DIV_LOG2, acc <= 0, avg_v <= 1; else avg_v <= 0.
//  Stage B (filter, on avg_v): x = ({avg}-8192)<<<2, signed 16 (range -32768..32764).
//   t = x - x_prev + y_state - (y_state>>>DC_SHIFT), computed 19-bit signed; y = sat16(t).
//   x_prev <= x; y_state <= y (saturated value); y_v <= 1 for one cycle.
//  Stage C (handoff, on y_v): pcm_o <= mute_i ? 0 : y; pcm_valid_o <= 1.
//   If pcm_valid_o & ~pcm_ready_i in that cycle, overrun_o <= 1; it stays sticky until reset.
//  Latency: last cycle of window (cycle W) -> avg_v at W+1 -> pcm_valid_o high at W+2.
//  Handshake: pcm_valid_o clears the cycle after valid&ready, unless y_v is high in the ready cycle.
//   If y_v and ready coincide, the new sample loads, valid stays 1 and there is no overrun.
//  pcm_o is stable while pcm_valid_o & ~pcm_ready_i, except when an overrun overwrites it.
//  Saturation: t > 32767 -> 32767; t < -32768 -> -32768. No wrap anywhere.
//  Stage C register samples mute_i; stage B does not.
// CONFIGURATION
//  FM7_AUDIO_DSM_EN defined:
//   First-order sigma-delta runs every CLKSYS cycle on u = pcm_o ^ 16'h8000 (offset binary).
//   s = {1'b0,dsm_acc} + u (17 bit); dsm_acc <= s[15:0]; dsm_o <= s[16].
//   Ones density = u/65536. Uses the held pcm_o, regardless of pcm_valid_o.
//  FM7_AUDIO_DSM_EN undefined: no DSM logic; dsm_o tied 0 (port kept).
// TESTING
//  1 mix=8192 constant, ready=1 -> every pcm_o=0; one valid pulse every 2**DIV_LOG2 cycles; overrun_o=0.
//  2 mix steps 8192->16383 at a window boundary -> consecutive samples 32764, 32733 (=32764-31), then decaying
//    toward 0 monotonically.
//  3 DIV_LOG2=4; mix=0 for 8 cycles then 16 for 8 cycles -> avg=8; pcm_valid_o exactly 2 cycles after window end.
//  4 ready=0 across two windows -> first sample held stable; second overwrites; overrun_o=1 and stays 1 with
//    ready=1 afterwards.
//  5 ready pulsed in the same cycle as the next y_v -> valid stays 1, new pcm_o loaded, overrun_o=0;
//    mute_i=1 -> pcm_o=0 while internal y keeps decaying.
//  6 FM7_AUDIO_DSM_EN, pcm_o=16384 held -> dsm_o density 0.75 (49152 ones per 65536 cycles);
//    RESETBn low mid-window -> all outputs 0 and the next sample appears at cycle 2**DIV_LOG2+1 after release.

Source files
------------

// File: rtl/fm7_psg_audio_out.sv
// ---------------------------------------------------------------------------
// fm7_psg_audio_out
//
// Audio output stage for the PSG mix. It does four things:
//   1. Box-averages the unsigned 14-bit mix over a window of 2**DIV_LOG2
//      CLKSYS cycles.
//   2. Recentres the average to a signed 16-bit value and removes DC with a
//      one-pole high-pass filter: y -= y >>> DC_SHIFT on every sample.
//   3. Saturates the filter output to signed 16-bit PCM.
//   4. Offers the PCM sample to the sink through a valid/ready holding
//      register. A sticky overrun flag is set when a sample is overwritten
//      before the sink has taken it.
//
// Parameters
//   DIV_LOG2  log2 of the window length in CLKSYS cycles (4..16)
//   DC_SHIFT  pole shift of the DC-blocking high-pass filter (4..15)
//
// Ports
//   CLKSYS       in   system clock (single clock domain)
//   RESETBn      in   asynchronous, active-low reset
//   mix_audio_i  in   [13:0] unsigned PSG mix, sampled every cycle
//   mute_i       in   forces the PCM payload to 0; the filter keeps running
//   pcm_o        out  [15:0] signed PCM sample
//   pcm_valid_o  out  pcm_o holds a sample the sink has not taken yet
//   pcm_ready_i  in   sink takes pcm_o when pcm_valid_o & pcm_ready_i
//   overrun_o    out  sticky: a sample was overwritten before it was taken
//   dsm_o        out  1-bit sigma-delta DAC output
//
// Build option
//   FM7_AUDIO_DSM_EN  When this macro is defined, a first-order sigma-delta
//                     modulator runs on the held pcm_o, converted to offset
//                     binary. When it is undefined, dsm_o is tied to 0.
//
// Latency
//   A window's last cycle is cycle W. The average is valid at W+1, and
//   pcm_valid_o goes high at W+2. The filter is combinational between the
//   average register and the PCM register.
// ---------------------------------------------------------------------------
module fm7_psg_audio_out #(
  parameter int DIV_LOG2 = 10,
  parameter int DC_SHIFT = 10
) (
  input  logic        CLKSYS,
  input  logic        RESETBn,
  input  logic [13:0] mix_audio_i,
  input  logic        mute_i,
  output logic [15:0] pcm_o,
  output logic        pcm_valid_o,
  input  logic        pcm_ready_i,
  output logic        overrun_o,
  output logic        dsm_o
);

  localparam int AW = 14 + DIV_LOG2;

  // Sign-extend a 16-bit two's-complement value to the 19-bit filter width.
  function automatic logic signed [18:0] sext16(input logic [15:0] v);
    sext16 = $signed({{3{v[15]}}, v});
  endfunction

  // Clamp a 19-bit signed intermediate to the signed 16-bit PCM range.
  function automatic logic [15:0] sat16(input logic signed [18:0] t);
    if (t > 19'sd32767) begin
      sat16 = 16'h7fff;
    end else if (t < -19'sd32768) begin
      sat16 = 16'h8000;
    end else begin
      sat16 = t[15:0];
    end
  endfunction

  // ---------------------------------------------------------------- window
  logic [DIV_LOG2-1:0] cnt_q, cnt_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [AW-1:0]       acc_sum_s;
  logic [13:0]         avg_q, avg_d;
  logic                avg_v_q, avg_v_d;

  // Window accumulation: the current mix is added in before the divide, so
  // the window really holds 2**DIV_LOG2 samples.
  always_comb begin
    acc_sum_s = acc_q + AW'(mix_audio_i);
    cnt_d     = cnt_q + DIV_LOG2'(1);
    avg_d     = avg_q;
    acc_d     = acc_sum_s;
    avg_v_d   = 1'b0;
    if (&cnt_q) begin
      avg_d   = acc_sum_s[AW-1:DIV_LOG2];
      acc_d   = '0;
      avg_v_d = 1'b1;
    end else begin
      avg_d   = avg_q;
      acc_d   = acc_sum_s;
      avg_v_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------- filter
  logic [15:0]        x_s;
  logic [15:0]        dc_s;
  logic signed [18:0] t_s;
  logic [15:0]        y_s;
  logic [15:0]        x_prev_q, x_prev_d;
  logic [15:0]        y_state_q, y_state_d;

  // High-pass filter datapath.
  // The recentring (avg - 8192) * 4 equals avg*4 - 32768. In 16 bits that
  // is the same as inverting the top bit of {avg, 2'b00}, so no adder is
  // needed.
  always_comb begin
    x_s  = {~avg_q[13], avg_q[12:0], 2'b00};
    dc_s = 16'($signed(y_state_q) >>> DC_SHIFT);
    t_s  = sext16(x_s) - sext16(x_prev_q) + sext16(y_state_q) - sext16(dc_s);
    y_s  = sat16(t_s);
  end

  // ---------------------------------------------------------------- handoff
  logic [15:0] pcm_q, pcm_d;
  logic        pcm_valid_q, pcm_valid_d;
  logic        overrun_q, overrun_d;

  // Filter state update and PCM holding register.
  // When a new sample arrives in the same cycle the sink takes the old one,
  // the register reloads and valid stays high. This case is not an overrun.
  always_comb begin
    x_prev_d    = x_prev_q;
    y_state_d   = y_state_q;
    pcm_d       = pcm_q;
    pcm_valid_d = pcm_valid_q;
    overrun_d   = overrun_q;
    if (avg_v_q) begin
      x_prev_d    = x_s;
      y_state_d   = y_s;
      pcm_d       = mute_i ? 16'h0000 : y_s;
      pcm_valid_d = 1'b1;
      if (pcm_valid_q & ~pcm_ready_i) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
    end else if (pcm_valid_q & pcm_ready_i) begin
      pcm_valid_d = 1'b0;
    end else begin
      pcm_valid_d = pcm_valid_q;
    end
  end

  // State registers for the window, filter and handoff stages.
  always_ff @(posedge CLKSYS or negedge RESETBn) begin
    if (!RESETBn) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      avg_q       <= 14'h0000;
      avg_v_q     <= 1'b0;
      x_prev_q    <= 16'h0000;
      y_state_q   <= 16'h0000;
      pcm_q       <= 16'h0000;
      pcm_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      avg_q       <= avg_d;
      avg_v_q     <= avg_v_d;
      x_prev_q    <= x_prev_d;
      y_state_q   <= y_state_d;
      pcm_q       <= pcm_d;
      pcm_valid_q <= pcm_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign pcm_o       = pcm_q;
  assign pcm_valid_o = pcm_valid_q;
  assign overrun_o   = overrun_q;

  // ---------------------------------------------------------------- DSM DAC
`ifdef FM7_AUDIO_DSM_EN
  logic [15:0] dsm_acc_q, dsm_acc_d;
  logic        dsm_q, dsm_d;
  logic [16:0] dsm_sum_s;

  // First-order sigma-delta modulator on the held sample.
  // Inverting the MSB converts signed PCM to offset binary, so the density
  // of ones equals u / 65536.
  always_comb begin
    dsm_sum_s = {1'b0, dsm_acc_q} + {1'b0, pcm_q ^ 16'h8000};
    dsm_acc_d = dsm_sum_s[15:0];
    dsm_d     = dsm_sum_s[16];
  end

  // Sigma-delta accumulator and output bit registers.
  always_ff @(posedge CLKSYS or negedge RESETBn) begin
    if (!RESETBn) begin
      dsm_acc_q <= 16'h0000;
      dsm_q     <= 1'b0;
    end else begin
      dsm_acc_q <= dsm_acc_d;
      dsm_q     <= dsm_d;
    end
  end

  assign dsm_o = dsm_q;
`else
  assign dsm_o = 1'b0;
`endif

endmodule

// File: tb/tb_fm7_psg_audio_out.sv
// ---------------------------------------------------------------------------
// tb_fm7_psg_audio_out
//
// Self-checking bench for fm7_psg_audio_out, built with DIV_LOG2=4 and
// DC_SHIFT=10.
//
// The reference model works on transactions:
//   - It adds up samples per window and divides by the window length.
//   - It runs the high-pass filter in integer arithmetic, with floor
//     division standing in for the arithmetic shift.
//   - It clamps the result to the signed 16-bit range.
//   - It keeps the handshake state in plain variables.
// When FM7_AUDIO_DSM_EN is defined, the expected sigma-delta ones count is
// floor(sum of u / 65536).
// ---------------------------------------------------------------------------
module tb_fm7_psg_audio_out;

  localparam int DL  = 4;
  localparam int DCS = 10;
  localparam int WIN = 1 << DL;

  logic        CLKSYS;
  logic        RESETBn;
  logic [13:0] mix_audio_i;
  logic        mute_i;
  logic [15:0] pcm_o;
  logic        pcm_valid_o;
  logic        pcm_ready_i;
  logic        overrun_o;
  logic        dsm_o;

  fm7_psg_audio_out #(.DIV_LOG2(DL), .DC_SHIFT(DCS)) dut (
    .CLKSYS     (CLKSYS),
    .RESETBn    (RESETBn),
    .mix_audio_i(mix_audio_i),
    .mute_i     (mute_i),
    .pcm_o      (pcm_o),
    .pcm_valid_o(pcm_valid_o),
    .pcm_ready_i(pcm_ready_i),
    .overrun_o  (overrun_o),
    .dsm_o      (dsm_o)
  );

  initial begin
    CLKSYS = 1'b0;
    forever #5 CLKSYS = ~CLKSYS;
  end

  int checks   = 0;
  int failures = 0;

  // ------------------------------------------------------------ reference
  int     m_sum, m_n, m_avg, m_xp, m_ys;
  bit     m_pending;
  int     exp_pcm;
  bit     exp_valid, exp_ovr, exp_dsm;
  longint m_u_total;

  function automatic int floor_div(input int v, input int d);
    if (v >= 0) return v / d;
    else        return -((-v + d - 1) / d);
  endfunction

  function automatic logic [18:0] exp_vec();
    logic [15:0] p;
    p = exp_pcm[15:0];
    return {p, exp_valid, exp_ovr, exp_dsm};
  endfunction

  function automatic logic [13:0] rmix();
    case ($urandom_range(0, 3))
      0:       return 14'd0;
      1:       return 14'd16383;
      default: return 14'($urandom_range(0, 16383));
    endcase
  endfunction

  task automatic model_reset();
    m_sum = 0; m_n = 0; m_avg = 0; m_xp = 0; m_ys = 0; m_pending = 0;
    exp_pcm = 0; exp_valid = 0; exp_ovr = 0; exp_dsm = 0; m_u_total = 0;
  endtask

  // One clock edge of behaviour, using the inputs present at that edge.
  task automatic model_edge(input int mix, input bit rdy, input bit mt);
    int x, t, y;
    longint prev;
    prev = m_u_total;
    m_u_total = m_u_total + longint'(exp_pcm + 32768);
`ifdef FM7_AUDIO_DSM_EN
    exp_dsm = ((m_u_total / 65536) - (prev / 65536)) != 0;
`else
    exp_dsm = 0;
`endif
    if (m_pending) begin
      x = (m_avg - 8192) * 4;
      t = x - m_xp + m_ys - floor_div(m_ys, 1 << DCS);
      y = (t > 32767) ? 32767 : ((t < -32768) ? -32768 : t);
      m_xp = x;
      m_ys = y;
      if (exp_valid && !rdy) exp_ovr = 1;
      exp_pcm   = mt ? 0 : y;
      exp_valid = 1;
    end else if (exp_valid && rdy) begin
      exp_valid = 0;
    end
    m_sum = m_sum + mix;
    m_n   = m_n + 1;
    if (m_n == WIN) begin
      m_avg = m_sum / WIN;
      m_sum = 0;
      m_n = 0;
      m_pending = 1;
    end else begin
      m_pending = 0;
    end
  endtask

  // ------------------------------------------------------------ drivers
  task automatic step(input logic [13:0] mix, input logic rdy, input logic mt);
    mix_audio_i = mix; pcm_ready_i = rdy; mute_i = mt;
    @(posedge CLKSYS); #1;
    model_edge(int'(mix), rdy, mt);
  endtask

  task automatic do_reset();
    RESETBn = 1'b0; mix_audio_i = 14'd0; mute_i = 1'b0; pcm_ready_i = 1'b1;
    @(posedge CLKSYS); #1;
    RESETBn = 1'b1;
    model_reset();
  endtask

  // ------------------------------------------------------------ tests
  task automatic test_reset();
    RESETBn = 1'b0; mix_audio_i = 14'h1abc; mute_i = 1'b0; pcm_ready_i = 1'b0;
    #2;
    checks++;
    if ({pcm_o, pcm_valid_o, overrun_o, dsm_o} !== 19'h00000) begin
      failures++; $display("FAIL reset_async: got %h expected 00000", {pcm_o, pcm_valid_o, overrun_o, dsm_o});
    end
    @(posedge CLKSYS); #1;
    checks++;
    if ({pcm_o, pcm_valid_o, overrun_o, dsm_o} !== 19'h00000) begin
      failures++; $display("FAIL reset_held: got %h expected 00000", {pcm_o, pcm_valid_o, overrun_o, dsm_o});
    end
    RESETBn = 1'b1;
    model_reset();
  endtask

  task automatic test_dc_zero();
    int pulses;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 4 * WIN + 1; i++) begin
      step(14'd8192, 1'b1, 1'b0);
      checks++;
      if ({pcm_o, pcm_valid_o, overrun_o, dsm_o} !== exp_vec()) begin
        failures++; $display("FAIL dc_zero edge %0d: got %h expected %h", i + 1, {pcm_o, pcm_valid_o, overrun_o, dsm_o}, exp_vec());
      end
      if (pcm_valid_o) pulses++;
    end
    checks++;
    if (pulses != 4) begin
      failures++; $display("FAIL dc_zero_pulses: got %0d expected 4", pulses);
    end
  endtask

  task automatic test_step();
    int samp[$];
    do_reset();
    for (int i = 0; i < 8 * WIN; i++) begin
      step((i < WIN) ? 14'd8192 : 14'd16383, 1'b1, 1'b0);
      checks++;
      if ({pcm_o, pcm_valid_o, overrun_o, dsm_o} !== exp_vec()) begin
        failures++; $display("FAIL step edge %0d: got %h expected %h", i + 1, {pcm_o, pcm_valid_o, overrun_o, dsm_o}, exp_vec());
      end
      if (pcm_valid_o) samp.push_back(int'($signed(pcm_o)));
    end
    checks++;
    if (samp.size() != 7) begin
      failures++; $display("FAIL step_count: got %0d expected 7", samp.size());
    end else begin
      checks++;
      if (samp[1] != 32764) begin
        failures++; $display("FAIL step_first: got %0d expected 32764", samp[1]);
      end
      checks++;
      if (samp[2] != 32733) begin
        failures++; $display("FAIL step_second: got %0d expected 32733", samp[2]);
      end
      for (int k = 3; k < 7; k++) begin
        checks++;
        if (!(samp[k] < samp[k-1] && samp[k] >= 0)) begin
          failures++; $display("FAIL step_decay[%0d]: got %0d expected below %0d and >= 0", k, samp[k], samp[k-1]);
        end
      end
    end
  endtask

  task automatic test_avg8();
    do_reset();
    for (int i = 0; i < WIN; i++) step((i < WIN / 2) ? 14'd0 : 14'd16, 1'b1, 1'b0);
    checks++;
    if (pcm_valid_o !== 1'b0) begin
      failures++; $display("FAIL avg8_early: got valid %b expected 0", pcm_valid_o);
    end
    step(14'd16, 1'b1, 1'b0);
    checks++;
    if ({pcm_valid_o, pcm_o} !== {1'b1, 16'h8020}) begin
      failures++; $display("FAIL avg8_sample: got valid %b pcm %0d expected valid 1 pcm -32736", pcm_valid_o, $signed(pcm_o));
    end
  endtask

  task automatic test_overrun();
    logic [15:0] first;
    do_reset();
    for (int i = 0; i < WIN + 1; i++) step(rmix(), 1'b0, 1'b0);
    first = pcm_o;
    for (int i = 0; i < WIN - 1; i++) begin
      step(rmix(), 1'b0, 1'b0);
      checks++;
      if ({pcm_o, pcm_valid_o, overrun_o} !== {first, 1'b1, 1'b0}) begin
        failures++; $display("FAIL overrun_hold: got %h expected %h", {pcm_o, pcm_valid_o, overrun_o}, {first, 1'b1, 1'b0});
      end
    end
    step(rmix(), 1'b0, 1'b0);
    checks++;
    if ({pcm_o, pcm_valid_o, overrun_o, dsm_o} !== exp_vec() || overrun_o !== 1'b1) begin
      failures++; $display("FAIL overrun_set: got %h expected %h", {pcm_o, pcm_valid_o, overrun_o, dsm_o}, exp_vec());
    end
    for (int i = 0; i < 3 * WIN; i++) step(rmix(), 1'b1, 1'b0);
    checks++;
    if (overrun_o !== 1'b1) begin
      failures++; $display("FAIL overrun_sticky: got %b expected 1", overrun_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 2 * WIN; i++) begin
      step((i < WIN) ? 14'd8192 : 14'd16383, 1'b0, 1'b0);
    end
    step(14'd16383, 1'b1, 1'b0);
    checks++;
    if ({pcm_o, pcm_valid_o, overrun_o} !== {16'd32764, 1'b1, 1'b0}) begin
      failures++; $display("FAIL b2b_load: got %h expected %h", {pcm_o, pcm_valid_o, overrun_o}, {16'd32764, 1'b1, 1'b0});
    end
    for (int i = 0; i < 5 * WIN; i++) begin
      step(14'd16383, 1'b1, (i < 3 * WIN) ? 1'b1 : 1'b0);
      checks++;
      if ({pcm_o, pcm_valid_o, overrun_o, dsm_o} !== exp_vec()) begin
        failures++; $display("FAIL b2b_mute edge %0d: got %h expected %h", i, {pcm_o, pcm_valid_o, overrun_o, dsm_o}, exp_vec());
      end
      if (i < 3 * WIN && pcm_valid_o) begin
        checks++;
        if (pcm_o !== 16'h0000) begin
          failures++; $display("FAIL mute_zero: got %0d expected 0", $signed(pcm_o));
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(rmix(), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
      checks++;
      if ({pcm_o, pcm_valid_o, overrun_o, dsm_o} !== exp_vec()) begin
        failures++; $display("FAIL random edge %0d: got %h expected %h", i, {pcm_o, pcm_valid_o, overrun_o, dsm_o}, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    do_reset();
    for (int i = 0; i < WIN + 8; i++) step(14'd16383, 1'b0, 1'b0);
    RESETBn = 1'b0;
    #1;
    checks++;
    if ({pcm_o, pcm_valid_o, overrun_o, dsm_o} !== 19'h00000) begin
      failures++; $display("FAIL reset_mid: got %h expected 00000", {pcm_o, pcm_valid_o, overrun_o, dsm_o});
    end
    @(posedge CLKSYS); #1;
    RESETBn = 1'b1;
    model_reset();
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      step(14'd12288, 1'b1, 1'b0);
      checks++;
      if ({pcm_o, pcm_valid_o, overrun_o, dsm_o} !== exp_vec()) begin
        failures++; $display("FAIL reset_mid edge %0d: got %h expected %h", i, {pcm_o, pcm_valid_o, overrun_o, dsm_o}, exp_vec());
      end
      if (pcm_valid_o) begin
        k = i;
        break;
      end
    end
    checks++;
    if (k != WIN + 1) begin
      failures++; $display("FAIL reset_mid_latency: got %0d expected %0d (0 = timeout)", k, WIN + 1);
    end
  endtask

  initial begin
    RESETBn = 1'b0; mix_audio_i = 14'd0; mute_i = 1'b0; pcm_ready_i = 1'b0;
    model_reset();
    test_reset();
    test_dc_zero();
    test_step();
    test_avg8();
    test_overrun();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
